// File: rtl/pulse_sequencer_if.sv
// Signal bundle between pulse_sequencer, its requester and the 4-bit counter.
//
// Signalling: there is no valid/ready pair. start and stop are level requests
// sampled on the rising clock edge (start only in IDLE, stop only in
// LOAD/RUN). tick and done are single-cycle strobes. c_out is the counter's
// combinational carry returned in the same cycle as the count it reflects.
interface pulse_sequencer_if;
    logic       start;
    logic       stop;
    logic [3:0] interval;
    logic [3:0] reps;
    logic       c_out;
    logic       cnt_load;
    logic       cnt_en;
    logic [3:0] cnt_load_in;
    logic       tick;
    logic       busy;
    logic       done;
    logic [4:0] remaining;

    // Sequencer side
    modport slave (
        input  start, stop, interval, reps, c_out,
        output cnt_load, cnt_en, cnt_load_in, tick, busy, done, remaining
    );

    // Requester / counter side
    modport master (
        output start, stop, interval, reps, c_out,
        input  cnt_load, cnt_en, cnt_load_in, tick, busy, done, remaining
    );
endinterface

// File: rtl/pulse_sequencer.sv
// Control FSM that turns a start request into R evenly spaced tick pulses by
// repeatedly preloading an external 4-bit up-counter with -L and waiting for
// its carry. Each repetition is one LOAD cycle plus L RUN cycles.
module pulse_sequencer (
    input  logic                    clk,
    input  logic                    reset,
    pulse_sequencer_if.slave        bus,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] interval_q;
    logic [4:0] remaining_q;
    logic       tick_q;
    logic       accept;
    logic       rep_end;

    // A start is accepted only from IDLE; a repetition ends on carry unless aborted
    assign accept  = (state == IDLE) && bus.start;
    assign rep_end = (state == RUN) && !bus.stop && bus.c_out;

    // Next-state selection and Moore outputs
    always_comb begin
        state_next   = state;
        bus.cnt_load = 1'b0;
        bus.cnt_en   = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = LOAD;
            end
            LOAD: begin
                bus.cnt_load = 1'b1;
                bus.busy     = 1'b1;
                state_next   = bus.stop ? IDLE : RUN;
            end
            RUN: begin
                bus.cnt_en = 1'b1;
                bus.busy   = 1'b1;
                if (bus.stop)
                    state_next = IDLE;
                else if (bus.c_out)
                    state_next = (remaining_q == 5'd1) ? DONE : LOAD;
            end
            DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, captured parameters, tick strobe and remaining count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            interval_q  <= 4'd0;
            remaining_q <= 5'd0;
            tick_q      <= 1'b0;
        end else begin
            state  <= state_next;
            tick_q <= rep_end;
            if (accept) begin
                interval_q  <= bus.interval;
                remaining_q <= (bus.reps == 4'd0) ? 5'd16 : {1'b0, bus.reps};
            end else if (rep_end) begin
                remaining_q <= remaining_q - 5'd1;
            end
        end
    end

    // Preload -L so the counter carries after exactly L enabled cycles; L=0 wraps to 16
    assign bus.cnt_load_in = (~interval_q) + 4'd1;
    assign bus.tick        = tick_q;
    assign bus.remaining   = remaining_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a behavioural 4-bit counter closes the loop,
// table vectors cover complete sequences, hand sequences cover abort and reset.
module tb_pulse_sequencer;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    logic [3:0] count;

    int n_checks;
    int n_errors;

    pulse_sequencer_if bus ();

    pulse_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: synchronous reset, then load, then enable
    always @(posedge clk) begin
        if (!reset)
            count <= 4'd0;
        else if (bus.cnt_load)
            count <= bus.cnt_load_in;
        else if (bus.cnt_en)
            count <= count + 4'd1;
    end
    assign bus.c_out = (count == 4'd15) && bus.cnt_en && !bus.cnt_load;

    typedef struct {
        logic [3:0] interval;
        logic [3:0] reps;
        logic       glitch;     // pulse start in cycle 3 and in the DONE cycle
        logic [3:0] exp_load_in;
        int         n_ticks;
        int         first_tick;
        int         period;
        int         done_cycle;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int cyc, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Runs one full sequence starting from IDLE at a negedge; cycle c lies
    // between rising edge c-1 and rising edge c, start is sampled at edge 0.
    task automatic run_seq(input vec_t v);
        int  ticks;
        logic e_tick, e_busy, e_done, e_load, e_en;
        int  e_rem;
        bus.start    = 1'b1;
        bus.interval = v.interval;
        bus.reps     = v.reps;
        @(negedge clk);
        for (int c = 1; c <= v.done_cycle + 1; c++) begin
            if (c < v.first_tick)
                ticks = 0;
            else
                ticks = (((c > v.done_cycle) ? v.done_cycle : c) - v.first_tick) / v.period + 1;
            e_tick = (c >= v.first_tick) && (c <= v.done_cycle) &&
                     ((c - v.first_tick) % v.period == 0);
            e_busy = (c <= v.done_cycle);
            e_done = (c == v.done_cycle);
            e_load = (c < v.done_cycle) && ((c - 1) % v.period == 0);
            e_en   = (c < v.done_cycle) && !e_load;
            e_rem  = v.n_ticks - ticks;
            check("tick", c, 32'(bus.tick), 32'(e_tick));
            check("done", c, 32'(bus.done), 32'(e_done));
            check("busy", c, 32'(bus.busy), 32'(e_busy));
            check("cnt_load", c, 32'(bus.cnt_load), 32'(e_load));
            check("cnt_en", c, 32'(bus.cnt_en), 32'(e_en));
            check("remaining", c, 32'(bus.remaining), 32'(e_rem));
            check("cnt_load_in", c, 32'(bus.cnt_load_in), 32'(v.exp_load_in));
            // Ignored start requests carry different parameters on purpose
            if (v.glitch && (c == 3 || c == v.done_cycle)) begin
                bus.start    = 1'b1;
                bus.interval = 4'd1;
                bus.reps     = 4'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        // interval, reps, glitch, load_in, ticks, first, period, done
        vecs[0] = '{4'd3, 4'd2, 1'b0, 4'd13, 2,  5,  4,  9};
        vecs[1] = '{4'd0, 4'd1, 1'b0, 4'd0,  1,  18, 17, 18};
        vecs[2] = '{4'd1, 4'd0, 1'b0, 4'd15, 16, 3,  2,  33};
        vecs[3] = '{4'd7, 4'd3, 1'b1, 4'd9,  3,  9,  8,  25};
        vecs[4] = '{4'd2, 4'd1, 1'b0, 4'd14, 1,  4,  3,  4};

        // Reset
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.interval = 4'd0;
        bus.reps     = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_state", 0, 32'(dbg_state), 32'd0);
        check("rst_busy", 0, 32'(bus.busy), 32'd0);
        check("rst_load_in", 0, 32'(bus.cnt_load_in), 32'd0);
        check("rst_remaining", 0, 32'(bus.remaining), 32'd0);
        check("rst_tick", 0, 32'(bus.tick | bus.done | bus.cnt_load | bus.cnt_en), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven complete sequences, back to back at earliest restart
        for (int i = 0; i < 4; i++) run_seq(vecs[i]);

        // Abort: L=5, R=4, stop in cycle 12 where the second carry occurs
        bus.start    = 1'b1;
        bus.interval = 4'd5;
        bus.reps     = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);                          // cycle 6
        check("abort_c_out1", 6, 32'(bus.c_out), 32'd1);
        @(negedge clk);                                     // cycle 7
        check("abort_tick1", 7, 32'(bus.tick), 32'd1);
        check("abort_rem1", 7, 32'(bus.remaining), 32'd3);
        repeat (5) @(negedge clk);                          // cycle 12
        check("abort_c_out2", 12, 32'(bus.c_out), 32'd1);
        bus.stop = 1'b1;
        @(negedge clk);                                     // cycle 13
        bus.stop = 1'b0;
        check("abort_state", 13, 32'(dbg_state), 32'd0);
        check("abort_busy", 13, 32'(bus.busy), 32'd0);
        check("abort_tick2", 13, 32'(bus.tick), 32'd0);
        check("abort_done", 13, 32'(bus.done), 32'd0);
        check("abort_rem", 13, 32'(bus.remaining), 32'd3);
        check("abort_load_in", 13, 32'(bus.cnt_load_in), 32'd11);
        repeat (3) @(negedge clk);
        check("abort_rem_hold", 16, 32'(bus.remaining), 32'd3);
        check("abort_quiet", 16, 32'(bus.tick | bus.done | bus.busy), 32'd0);

        // Asynchronous reset in the middle of RUN: L=4, R=3
        bus.start    = 1'b1;
        bus.interval = 4'd4;
        bus.reps     = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);                          // cycle 3, RUN
        check("mid_en", 3, 32'(bus.cnt_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_state", 3, 32'(dbg_state), 32'd0);
        check("async_busy", 3, 32'(bus.busy), 32'd0);
        check("async_en", 3, 32'(bus.cnt_en), 32'd0);
        check("async_load_in", 3, 32'(bus.cnt_load_in), 32'd0);
        check("async_remaining", 3, 32'(bus.remaining), 32'd0);
        check("async_strobes", 3, 32'(bus.tick | bus.done | bus.cnt_load), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_seq(vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
